// File: rtl/seq_control_param.sv
// Drum-machine sequencer controller: steps through NUM_INS pattern loads and a
// BPM load, then runs a STEPS-long beat loop paced by beat_tick.
module seq_control_param #(
  parameter int NUM_INS = 4,
  parameter int STEPS   = 8,
  parameter int STEP_W  = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               stop,
  input  logic               bpm_zero,
  input  logic               beat_tick,
  output logic [NUM_INS-1:0] ld_ins,
  output logic               ld_bpm,
  output logic               play,
  output logic               paused,
  output logic [STEP_W-1:0]  timing,
  output logic               step_strobe,
  output logic               bar_done
);

  localparam int                 IDX_W     = (NUM_INS > 1) ? $clog2(NUM_INS) : 1;
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_INS - 1);
  localparam logic [IDX_W:0]     IDX_LIMIT = (IDX_W + 1)'(NUM_INS);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEPS - 1);
  localparam logic [NUM_INS-1:0] INS_ONE   = NUM_INS'(1);

  typedef enum logic [2:0] {
    S_LOAD_INS,
    S_LOAD_INS_WAIT,
    S_LOAD_BPM,
    S_LOAD_BPM_WAIT,
    S_PLAY,
    S_PAUSE_WAIT,
    S_PAUSE,
    S_RESUME_WAIT
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [STEP_W-1:0] timing_n;
  logic              step_strobe_n;
  logic              bar_done_n;
  logic              idx_ok;

  // The widened compare keeps this meaningful when NUM_INS is not a power of two.
  assign idx_ok = ({1'b0, idx} < IDX_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_LOAD_INS;
      idx         <= '0;
      timing      <= '0;
      step_strobe <= 1'b0;
      bar_done    <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      timing      <= timing_n;
      step_strobe <= step_strobe_n;
      bar_done    <= bar_done_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    timing_n      = timing;
    step_strobe_n = 1'b0;
    bar_done_n    = 1'b0;

    case (state)
      S_LOAD_INS: begin
        if (!idx_ok) begin
          idx_n = '0;
        end else if (go) begin
          state_n = S_LOAD_INS_WAIT;
        end
      end

      S_LOAD_INS_WAIT: begin
        if (!idx_ok) begin
          state_n = S_LOAD_INS;
          idx_n   = '0;
        end else if (!go) begin
          if (idx == IDX_LAST) begin
            state_n = S_LOAD_BPM;
          end else begin
            state_n = S_LOAD_INS;
            idx_n   = idx + 1'b1;
          end
        end
      end

      S_LOAD_BPM: begin
        if (go) state_n = S_LOAD_BPM_WAIT;
      end

      S_LOAD_BPM_WAIT: begin
        if (!go) begin
          if (bpm_zero) begin
            state_n = S_LOAD_BPM;
          end else begin
            state_n       = S_PLAY;
            timing_n      = '0;
            step_strobe_n = 1'b1;
          end
        end
      end

      S_PLAY: begin
        if (stop) begin
          state_n  = S_LOAD_INS;
          idx_n    = '0;
          timing_n = '0;
        end else begin
          // A tick coinciding with a pause press still advances the beat.
          if (beat_tick) begin
            timing_n      = (timing == STEP_LAST) ? '0 : timing + 1'b1;
            step_strobe_n = 1'b1;
            bar_done_n    = (timing == STEP_LAST);
          end
          if (go) state_n = S_PAUSE_WAIT;
        end
      end

      S_PAUSE_WAIT: begin
        if (stop) begin
          state_n  = S_LOAD_INS;
          idx_n    = '0;
          timing_n = '0;
        end else if (!go) begin
          state_n = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_n  = S_LOAD_INS;
          idx_n    = '0;
          timing_n = '0;
        end else if (go) begin
          state_n = S_RESUME_WAIT;
        end
      end

      S_RESUME_WAIT: begin
        if (stop) begin
          state_n  = S_LOAD_INS;
          idx_n    = '0;
          timing_n = '0;
        end else if (!go) begin
          state_n = S_PLAY;
        end
      end

      default: begin
        state_n  = S_LOAD_INS;
        idx_n    = '0;
        timing_n = '0;
      end
    endcase
  end

  // Load enables and play/pause flags are pure decodes, so at most one is high.
  always_comb begin
    ld_ins = '0;
    ld_bpm = 1'b0;
    play   = 1'b0;
    paused = 1'b0;
    case (state)
      S_LOAD_INS:                          ld_ins = INS_ONE << idx;
      S_LOAD_BPM:                          ld_bpm = 1'b1;
      S_PLAY:                              play   = 1'b1;
      S_PAUSE_WAIT, S_PAUSE, S_RESUME_WAIT: paused = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_param.sv
// Self-checking bench for seq_control_param: a 4x8 instance and a 6x12 instance
// checked against an item/beat-level behavioural model.
module tb_seq_control_param;

  logic clk = 1'b0;
  logic reset_a = 1'b0, reset_b = 1'b0;
  logic go = 1'b0, stop = 1'b0, bpm_zero = 1'b0, beat_tick = 1'b0;

  logic [3:0] ld_ins_a;
  logic       ld_bpm_a, play_a, paused_a, step_strobe_a, bar_done_a;
  logic [2:0] timing_a;
  logic [5:0] ld_ins_b;
  logic       ld_bpm_b, play_b, paused_b, step_strobe_b, bar_done_b;
  logic [3:0] timing_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_control_param #(.NUM_INS(4), .STEPS(8)) dut_a (
    .clk(clk), .reset(reset_a), .go(go), .stop(stop), .bpm_zero(bpm_zero),
    .beat_tick(beat_tick), .ld_ins(ld_ins_a), .ld_bpm(ld_bpm_a), .play(play_a),
    .paused(paused_a), .timing(timing_a), .step_strobe(step_strobe_a),
    .bar_done(bar_done_a)
  );

  seq_control_param #(.NUM_INS(6), .STEPS(12)) dut_b (
    .clk(clk), .reset(reset_b), .go(go), .stop(stop), .bpm_zero(bpm_zero),
    .beat_tick(beat_tick), .ld_ins(ld_ins_b), .ld_bpm(ld_bpm_b), .play(play_b),
    .paused(paused_b), .timing(timing_b), .step_strobe(step_strobe_b),
    .bar_done(bar_done_b)
  );

  // Reference model: which item is being loaded (NI = the BPM item), whether a
  // press is awaiting release, and the beat counter while in playback.
  int NI[2] = '{4, 6};
  int ST[2] = '{8, 12};
  int m_item[2], m_beat[2];
  bit m_pb[2], m_hold[2], m_run[2], m_resp[2], m_stb[2], m_bar[2];

  task automatic model_step(input int d, input logic rst);
    if (!rst) begin
      m_pb[d] = 0; m_hold[d] = 0; m_run[d] = 0; m_resp[d] = 0;
      m_item[d] = 0; m_beat[d] = 0; m_stb[d] = 0; m_bar[d] = 0;
    end else begin
      m_stb[d] = 0;
      m_bar[d] = 0;
      if (m_pb[d]) begin
        if (stop) begin
          m_pb[d] = 0; m_hold[d] = 0; m_item[d] = 0; m_beat[d] = 0;
        end else if (m_run[d]) begin
          if (beat_tick) begin
            m_beat[d] = (m_beat[d] + 1) % ST[d];
            m_stb[d]  = 1;
            m_bar[d]  = (m_beat[d] == 0);
          end
          if (go) begin m_run[d] = 0; m_hold[d] = 1; m_resp[d] = 0; end
        end else if (m_hold[d]) begin
          if (!go) begin
            m_hold[d] = 0;
            if (m_resp[d]) m_run[d] = 1;
          end
        end else if (go) begin
          m_hold[d] = 1; m_resp[d] = 1;
        end
      end else begin
        if (!m_hold[d]) begin
          if (go) m_hold[d] = 1;
        end else if (!go) begin
          m_hold[d] = 0;
          if (m_item[d] < NI[d]) m_item[d]++;
          else if (!bpm_zero) begin
            m_pb[d] = 1; m_run[d] = 1; m_beat[d] = 0; m_stb[d] = 1;
          end
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, reset_a);
    model_step(1, reset_b);
  end

  // Packing: [20:13] ld_ins, [12] ld_bpm, [11] play, [10] paused, [9:2] timing, [1] strobe, [0] bar
  function automatic logic [20:0] exp_vec(input int d);
    logic [7:0] li = '0;
    if (!m_pb[d] && !m_hold[d] && m_item[d] < NI[d]) li = 8'd1 << m_item[d];
    return {li, (!m_pb[d] && !m_hold[d] && m_item[d] == NI[d]),
            (m_pb[d] && m_run[d]), (m_pb[d] && !m_run[d]),
            8'(m_beat[d]), m_stb[d], m_bar[d]};
  endfunction

  function automatic logic [20:0] act_vec(input int d);
    if (d == 0)
      return {4'b0, ld_ins_a, ld_bpm_a, play_a, paused_a, 5'b0, timing_a, step_strobe_a, bar_done_a};
    return {2'b0, ld_ins_b, ld_bpm_b, play_b, paused_b, 4'b0, timing_b, step_strobe_b, bar_done_b};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold);
    go = 1'b1;
    cyc(hold);
    go = 1'b0;
    cyc(1);
  endtask

  task automatic test_reset();
    reset_a = 1'b0; reset_b = 1'b0;
    cyc(2);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (act_vec(d) !== exp_vec(d)) begin
        failures++;
        $display("FAIL reset_model dut%0d: got %h expected %h", d, act_vec(d), exp_vec(d));
      end
    end
    checks++;
    if ({ld_ins_a, ld_bpm_a, play_a, paused_a, timing_a, step_strobe_a, bar_done_a} !== 12'b0001_000_000_00) begin
      failures++;
      $display("FAIL reset_outputs: got ld_ins=%b ld_bpm=%b play=%b paused=%b timing=%0d strobe=%b bar=%b expected 0001/0/0/0/0/0/0",
               ld_ins_a, ld_bpm_a, play_a, paused_a, timing_a, step_strobe_a, bar_done_a);
    end
  endtask

  task automatic test_load();
    reset_a = 1'b1;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ld_ins_a !== 4'(1 << k) || ld_bpm_a !== 1'b0) begin
        failures++;
        $display("FAIL load_ins_%0d: got ld_ins=%b ld_bpm=%b expected %b/0", k, ld_ins_a, ld_bpm_a, 4'(1 << k));
      end
      press(3);
    end
    checks++;
    if (ld_bpm_a !== 1'b1 || ld_ins_a !== 4'b0000) begin
      failures++;
      $display("FAIL load_bpm: got ld_bpm=%b ld_ins=%b expected 1/0000", ld_bpm_a, ld_ins_a);
    end
    press(3);
    checks++;
    if (play_a !== 1'b1 || timing_a !== 3'd0 || step_strobe_a !== 1'b1 || bar_done_a !== 1'b0) begin
      failures++;
      $display("FAIL play_entry: got play=%b timing=%0d strobe=%b bar=%b expected 1/0/1/0", play_a, timing_a, step_strobe_a, bar_done_a);
    end
    cyc(1);
    checks++;
    if (step_strobe_a !== 1'b0 || act_vec(0) !== exp_vec(0)) begin
      failures++;
      $display("FAIL play_entry_single: got %h expected %h", act_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_wrap(input int d);
    int strobes = 0;
    int bars = 0;
    logic [20:0] v;
    for (int k = 1; k <= ST[d]; k++) begin
      beat_tick = 1'b1;
      cyc(1);
      beat_tick = 1'b0;
      v = act_vec(d);
      checks++;
      if (v[9:2] !== 8'(k % ST[d]) || v[1] !== 1'b1 || v[0] !== (k == ST[d])) begin
        failures++;
        $display("FAIL wrap_step dut%0d k=%0d: got timing=%0d strobe=%b bar=%b expected %0d/1/%0d",
                 d, k, v[9:2], v[1], v[0], k % ST[d], (k == ST[d]));
      end
      strobes += int'(v[1]);
      bars    += int'(v[0]);
      repeat (9) begin
        cyc(1);
        v = act_vec(d);
        strobes += int'(v[1]);
        bars    += int'(v[0]);
      end
    end
    checks++;
    if (strobes != ST[d] || bars != 1) begin
      failures++;
      $display("FAIL wrap_counts dut%0d: got strobes=%0d bars=%0d expected %0d/1", d, strobes, bars, ST[d]);
    end
  endtask

  task automatic test_bpm_zero();
    reset_a = 1'b0;
    cyc(1);
    reset_a = 1'b1;
    for (int k = 0; k < 4; k++) press(2);
    bpm_zero = 1'b1;
    press(2);
    bpm_zero = 1'b0;
    checks++;
    if (ld_bpm_a !== 1'b1 || play_a !== 1'b0) begin
      failures++;
      $display("FAIL bpm_zero_reject: got ld_bpm=%b play=%b expected 1/0", ld_bpm_a, play_a);
    end
    press(2);
    checks++;
    if (play_a !== 1'b1 || timing_a !== 3'd0 || step_strobe_a !== 1'b1) begin
      failures++;
      $display("FAIL bpm_retry: got play=%b timing=%0d strobe=%b expected 1/0/1", play_a, timing_a, step_strobe_a);
    end
  endtask

  task automatic test_pause();
    repeat (3) begin
      beat_tick = 1'b1; cyc(1); beat_tick = 1'b0; cyc(1);
    end
    go = 1'b1;
    cyc(1);
    checks++;
    if (paused_a !== 1'b1 || play_a !== 1'b0 || timing_a !== 3'd3) begin
      failures++;
      $display("FAIL pause_enter: got paused=%b play=%b timing=%0d expected 1/0/3", paused_a, play_a, timing_a);
    end
    beat_tick = 1'b1;
    cyc(2);
    go = 1'b0;
    cyc(3);
    beat_tick = 1'b0;
    checks++;
    if (paused_a !== 1'b1 || timing_a !== 3'd3 || step_strobe_a !== 1'b0) begin
      failures++;
      $display("FAIL pause_frozen: got paused=%b timing=%0d strobe=%b expected 1/3/0", paused_a, timing_a, step_strobe_a);
    end
    press(2);
    checks++;
    if (play_a !== 1'b1 || paused_a !== 1'b0 || step_strobe_a !== 1'b0 || timing_a !== 3'd3) begin
      failures++;
      $display("FAIL resume: got play=%b paused=%b strobe=%b timing=%0d expected 1/0/0/3", play_a, paused_a, step_strobe_a, timing_a);
    end
    beat_tick = 1'b1; cyc(1); beat_tick = 1'b0;
    checks++;
    if (timing_a !== 3'd4 || step_strobe_a !== 1'b1) begin
      failures++;
      $display("FAIL resume_tick: got timing=%0d strobe=%b expected 4/1", timing_a, step_strobe_a);
    end
    cyc(1);
  endtask

  task automatic test_stop();
    beat_tick = 1'b1; cyc(1); beat_tick = 1'b0; cyc(2);
    checks++;
    if (timing_a !== 3'd5) begin
      failures++;
      $display("FAIL stop_setup: got timing=%0d expected 5", timing_a);
    end
    stop = 1'b1; beat_tick = 1'b1;
    cyc(1);
    stop = 1'b0; beat_tick = 1'b0;
    checks++;
    if (ld_ins_a !== 4'b0001 || timing_a !== 3'd0 || step_strobe_a !== 1'b0 || bar_done_a !== 1'b0 || play_a !== 1'b0) begin
      failures++;
      $display("FAIL stop_tick: got ld_ins=%b timing=%0d strobe=%b bar=%b play=%b expected 0001/0/0/0/0",
               ld_ins_a, timing_a, step_strobe_a, bar_done_a, play_a);
    end
    stop = 1'b1;
    press(2);
    stop = 1'b0;
    checks++;
    if (ld_ins_a !== 4'b0010) begin
      failures++;
      $display("FAIL stop_ignored_in_load: got ld_ins=%b expected 0010", ld_ins_a);
    end
    for (int k = 1; k < 4; k++) press(2);
    reset_a = 1'b0;
    cyc(1);
    checks++;
    if (ld_ins_a !== 4'b0001 || ld_bpm_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_bpm: got ld_ins=%b ld_bpm=%b expected 0001/0", ld_ins_a, ld_bpm_a);
    end
    reset_a = 1'b1;
    cyc(1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) press(1);
    beat_tick = 1'b1;
    cyc(1);
    checks++;
    if (timing_a !== 3'd1) begin
      failures++;
      $display("FAIL b2b_first: got timing=%0d expected 1", timing_a);
    end
    cyc(1);
    checks++;
    if (timing_a !== 3'd2 || step_strobe_a !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second: got timing=%0d strobe=%b expected 2/1", timing_a, step_strobe_a);
    end
    go = 1'b1;
    cyc(1);
    beat_tick = 1'b0;
    checks++;
    if (timing_a !== 3'd3 || paused_a !== 1'b1 || step_strobe_a !== 1'b1) begin
      failures++;
      $display("FAIL tick_with_go: got timing=%0d paused=%b strobe=%b expected 3/1/1", timing_a, paused_a, step_strobe_a);
    end
    go = 1'b0;
    cyc(1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    checks++;
    if (ld_ins_a !== 4'b0001 || paused_a !== 1'b0 || timing_a !== 3'd0) begin
      failures++;
      $display("FAIL stop_from_pause: got ld_ins=%b paused=%b timing=%0d expected 0001/0/0", ld_ins_a, paused_a, timing_a);
    end
  endtask

  task automatic test_random(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      go        = ($urandom_range(0, 3) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      beat_tick = ($urandom_range(0, 2) == 0);
      bpm_zero  = ($urandom_range(0, 2) == 0);
      if (d == 0) reset_a = ($urandom_range(0, 399) != 0);
      else        reset_b = ($urandom_range(0, 399) != 0);
      cyc(1);
      for (int e = 0; e < 2; e++) begin
        checks++;
        if (act_vec(e) !== exp_vec(e)) begin
          failures++;
          $display("FAIL random dut%0d cycle %0d: got %h expected %h", e, i, act_vec(e), exp_vec(e));
        end
      end
    end
    go = 1'b0; stop = 1'b0; beat_tick = 1'b0; bpm_zero = 1'b0;
    cyc(1);
  endtask

  task automatic test_param();
    reset_a = 1'b0; reset_b = 1'b0;
    cyc(1);
    reset_b = 1'b1;
    cyc(1);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ld_ins_b !== 6'(1 << k)) begin
        failures++;
        $display("FAIL param_load_%0d: got ld_ins=%b expected %b", k, ld_ins_b, 6'(1 << k));
      end
      press(3);
    end
    checks++;
    if (ld_bpm_b !== 1'b1) begin
      failures++;
      $display("FAIL param_bpm: got ld_bpm=%b expected 1", ld_bpm_b);
    end
    press(3);
    checks++;
    if (play_b !== 1'b1 || timing_b !== 4'd0 || step_strobe_b !== 1'b1) begin
      failures++;
      $display("FAIL param_play: got play=%b timing=%0d strobe=%b expected 1/0/1", play_b, timing_b, step_strobe_b);
    end
    cyc(1);
    test_wrap(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_wrap(0);
    test_bpm_zero();
    test_pause();
    test_stop();
    test_back_to_back();
    test_random(0, 2500);
    test_param();
    test_random(1, 2500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_control_param.md
# seq_control_param

Parametrised sequencer controller for the drum-machine datapath. It walks the user through loading `NUM_INS` instrument patterns and a BPM value, using one `go` press per item. It then runs a `STEPS`-long beat loop paced by a `beat_tick` strobe, with pause/resume on `go` and return-to-load on `stop`. It replaces the fixed 4-instrument/8-beat controller and its separate slow clock: everything runs on `clk`.

## Interface
Parameters:
- `NUM_INS`, 4, number of instrument pattern registers to load (≥1)
- `STEPS`, 8, beats per loop (≥2, need not be a power of two)
- `STEP_W`, `$clog2(STEPS)`, width of `timing` (derived, not overridden)

Ports:
- `clk` in 1: system clock; all logic on its rising edge
- `reset` in 1: synchronous, active-low
- `go` in 1: level button input, high while pressed; debounced externally
- `stop` in 1: level; abort playback and return to loading
- `bpm_zero` in 1: datapath flag, high when the BPM value being loaded is 0
- `beat_tick` in 1: one-`clk` strobe marking each beat period
- `ld_ins` out `NUM_INS`: one-hot load enable for the instrument register
- `ld_bpm` out 1: BPM register load enable
- `play` out 1: high while actively playing
- `paused` out 1: high while paused
- `timing` out `STEP_W`: current beat index, 0..`STEPS`-1
- `step_strobe` out 1: one-cycle pulse when `timing` takes a new value to be sounded
- `bar_done` out 1: one-cycle pulse coincident with `step_strobe` when `timing` wraps to 0

## Operation
- **States:** LOAD_INS, LOAD_INS_WAIT, LOAD_BPM, LOAD_BPM_WAIT, PLAY, PAUSE_WAIT, PAUSE, RESUME_WAIT.
- **Instrument index:** an index counter `idx` (0..`NUM_INS`-1) qualifies LOAD_INS/LOAD_INS_WAIT.
- **LOAD_INS:** `ld_ins[idx]`=1.
  - `go`=1 → LOAD_INS_WAIT.
- **LOAD_INS_WAIT:** holds while `go`=1. On release:
  - if `idx`=`NUM_INS`-1 → LOAD_BPM;
  - else `idx`+1, → LOAD_INS.
- **LOAD_BPM:** `ld_bpm`=1.
  - `go`=1 → LOAD_BPM_WAIT.
- **LOAD_BPM_WAIT:** on `go` release:
  - `bpm_zero`=1 → LOAD_BPM (zero BPM rejected);
  - else → PLAY, with `timing`←0 and `step_strobe`=1 on the first PLAY cycle.
- **PLAY:** `play`=1. Each `beat_tick` sampled in PLAY produces, next cycle:
  - `timing`←(`timing`=`STEPS`-1) ? 0 : `timing`+1;
  - `step_strobe`=1;
  - `bar_done`=1 iff the new value is 0.
  - `go`=1 → PAUSE_WAIT.
- **PAUSE_WAIT / PAUSE:** `paused`=1, `play`=0, `timing` frozen, `beat_tick` ignored.
  - PAUSE_WAIT: on `go` release → PAUSE.
  - PAUSE: `go`=1 → RESUME_WAIT.
- **RESUME_WAIT:** `paused`=1, `play`=0; on `go` release → PLAY. Resume produces no strobe; playback continues from the frozen `timing`.
- **`stop`:** with `stop`=1 in PLAY, PAUSE_WAIT, PAUSE or RESUME_WAIT, the next state is LOAD_INS with `idx`=0, `timing`=0, and no strobes. `stop` overrides `go` and `beat_tick` in the same cycle. `stop` is ignored in all load states.
- **Output decoding:** `ld_ins`, `ld_bpm`, `play` and `paused` are combinational decodes of state/`idx`. Exactly one or none of them is high; never two.
- **Illegal state encoding:** recovers to LOAD_INS with `idx`=0 on the next edge.

## Timing
- **Reset:** `reset`=0 at an edge gives state LOAD_INS, `idx`=0, `timing`=0, `step_strobe`=0, `bar_done`=0. Consequently `ld_ins`=1 (bit 0 only), `ld_bpm`=0, `play`=0, `paused`=0. Reset mid-play or mid-load has the same effect.
- **`go` handling:** `go` rising is seen at the next edge, so a load state lasts ≥1 cycle. A press is consumed on release, so one press advances exactly one item regardless of hold length.
- **Beat latency:** 1 cycle from `beat_tick` to the `timing`/`step_strobe` update.
- **Simultaneous events in PLAY:**
  - `beat_tick` with `go`=1: the tick is still applied (`timing` advances) and the state moves to PAUSE_WAIT.
  - Back-to-back `beat_tick` on consecutive cycles: each one advances `timing`.

## Test plan
- **Load sequence:** reset, then 5 `go` presses (each held 3 cycles) with `bpm_zero`=0 → `ld_ins` reads 0001, 0010, 0100, 1000 in turn, then `ld_bpm`=1. After the 5th release, `play`=1, `timing`=0, `step_strobe`=1 for one cycle.
- **Wrap:** in PLAY with `STEPS`=8, apply 8 `beat_tick` pulses 10 cycles apart → `timing` 1..7 then 0. `bar_done` pulses only on the 8th update. `step_strobe` pulses 8 times.
- **Zero BPM rejection:** `bpm_zero`=1 at the BPM `go` release → returns to LOAD_BPM (`ld_bpm`=1, `play`=0). A retry with `bpm_zero`=0 → PLAY.
- **Pause/resume:** at `timing`=3, press `go` → `paused`=1, and ticks during the pause leave `timing`=3. Press again → `play`=1 with no strobe; the next tick gives `timing`=4.
- **Stop and reset:** `stop` with a simultaneous `beat_tick` at `timing`=5 → next cycle LOAD_INS, `ld_ins`=0001, `timing`=0, no strobe. `reset`=0 while in LOAD_BPM → `ld_ins`=0001.
- **Parametrisation:** rerun the load and wrap scenarios with `NUM_INS`=6, `STEPS`=12 → six one-hot loads; `timing` wraps 11→0 with `bar_done`.
